// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Two-master round-robin arbiter in front of one shared data-bus
//               slave. The FSM moves IDLE -> GNTi -> IDLE, which leaves a
//               one-cycle bubble between transfers. The optional watchdog is
//               enabled by defining DBUS_ARB_TIMEOUT_EN. When it fires, the
//               granted master receives an error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  gnt
);

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q;
  logic   last_q;   // master that completed most recently
  logic   w_in0;
  logic   w_in1;
  logic   w_tmo;    // watchdog fires this cycle
  logic   w_done;   // transfer completes this cycle (normal or timeout)

  assign w_in0  = (state_q == GNT0);
  assign w_in1  = (state_q == GNT1);
  assign w_done = (w_in0 || w_in1) && (s_ack || w_tmo);
  assign gnt    = state_q;

`ifdef DBUS_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Counts grant cycles without s_ack. The counter stays at zero in IDLE, so
  // every new grant starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (!s_ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // If s_ack arrives on the last allowed cycle, it wins over the timeout.
  assign w_tmo = (w_in0 || w_in1) && !s_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign w_tmo              = 1'b0;
`endif

  // Route the granted master to the slave. Drive zeros when no master is
  // granted. Suppress the request on a timeout cycle.
  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_wstrb = 4'd0;
    if (w_in0) begin
      s_req   = m0_req && !w_tmo;
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (w_in1) begin
      s_req   = m1_req && !w_tmo;
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

  // Return the completion only to the granted master. A timeout completion
  // carries zero read data.
  always_comb begin
    m0_ack   = w_in0 && (s_ack || w_tmo);
    m1_ack   = w_in1 && (s_ack || w_tmo);
    m0_err   = w_in0 && w_tmo;
    m1_err   = w_in1 && w_tmo;
    m0_rdata = (w_in0 && s_ack) ? s_rdata : 32'd0;
    m1_rdata = (w_in1 && s_ack) ? s_rdata : 32'd0;
  end

  // Arbitration FSM with round-robin pointer. last resets to 1, so master 0
  // wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            state_q <= last_q ? GNT0 : GNT1;
          end else if (m0_req) begin
            state_q <= GNT0;
          end else if (m1_req) begin
            state_q <= GNT1;
          end
        end
        GNT0: begin
          if (w_done) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
          end else if (!m0_req) begin
            // Master abandoned the request: drop it without a completion.
            state_q <= IDLE;
          end
        end
        GNT1: begin
          if (w_done) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
          end else if (!m1_req) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_arbiter
// Description : Directed testbench for dbus_arbiter. A scoreboard queue holds
//               the expected completions, and a monitor checks every ack.
//               The watchdog section follows DBUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic [1:0]  gnt;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ack(s_ack), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait, with a bound, for any grant. Then check that it is the expected one.
  task automatic wait_gnt(input string name, input logic [1:0] exp);
    int k = 0;
    step();
    while (gnt == 2'b00 && k < 20) begin
      step();
      k++;
    end
    chk(name, {30'd0, gnt}, {30'd0, exp});
  endtask

  // The slave acks in the current cycle. While ack is high, the other master's
  // response outputs must stay zero.
  task automatic slave_ack(input logic [31:0] d, input logic id);
    s_rdata = d;
    s_ack   = 1'b1;
    @(negedge clk);
    if (id) chk("other_quiet", {m0_ack, m0_err, m0_rdata[29:0]}, 32'd0);
    else    chk("other_quiet", {m1_ack, m1_err, m1_rdata[29:0]}, 32'd0);
    @(posedge clk);
    #1;
    s_ack   = 1'b0;
    s_rdata = 32'd0;
    chk("ack_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic push(input logic id, input logic [31:0] d, input logic err);
    exp_t e;
    e.id    = id;
    e.rdata = d;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Monitor: each ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && (m0_ack || m1_ack)) begin
      if (m0_ack && m1_ack) begin
        chk("dual_ack", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        chk("unexpected_ack", {31'd0, m1_ack}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_master", {31'd0, m1_ack}, {31'd0, e.id});
        chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
        chk("ack_err", {31'd0, m1_ack ? m1_err : m0_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_rdata = 0; s_ack = 0;
    repeat (3) step();

    // Reset state
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_slave", {27'd0, s_req, s_we, s_wstrb}, 32'd0);
    chk("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // m0 read; the slave acks two cycles after s_req
    m0_addr = 32'h1000_0040; m0_we = 1'b0; m0_req = 1'b1;
    wait_gnt("rd_gnt", 2'b01);
    chk("rd_sreq", {31'd0, s_req}, 32'd1);
    chk("rd_saddr", s_addr, 32'h1000_0040);
    chk("rd_swe", {31'd0, s_we}, 32'd0);
    step();
    step();
    push(1'b0, 32'hCAFE_F00D, 1'b0);
    slave_ack(32'hCAFE_F00D, 1'b0);
    m0_req = 1'b0;
    chk("rd_idle", {30'd0, gnt}, 32'd0);

    // Contention from reset: 0,1,0,1 with one idle cycle between grants
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("rr_gnt", (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_saddr", s_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      push(i[0], 32'hA000_0000 + 32'(i), 1'b0);
      slave_ack(32'hA000_0000 + 32'(i), i[0]);
      chk("rr_bubble", {30'd0, gnt}, 32'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();

    // m1 write: slave signals come from m1, and m0 outputs stay quiet
    m1_we = 1'b1; m1_addr = 32'h2000_0010; m1_wdata = 32'h1234_5678;
    m1_wstrb = 4'b0011; m1_req = 1'b1;
    wait_gnt("wr_gnt", 2'b10);
    chk("wr_sreq", {31'd0, s_req}, 32'd1);
    chk("wr_swe", {31'd0, s_we}, 32'd1);
    chk("wr_saddr", s_addr, 32'h2000_0010);
    chk("wr_swdata", s_wdata, 32'h1234_5678);
    chk("wr_swstrb", {28'd0, s_wstrb}, 32'd3);
    chk("wr_m0_quiet", {m0_ack, m0_err, m0_rdata[29:0]}, 32'd0);
    push(1'b1, 32'h0BAD_0001, 1'b0);
    slave_ack(32'h0BAD_0001, 1'b1);
    m1_req = 1'b0; m1_we = 1'b0; m1_wstrb = 4'd0;
    step();

    // A stray s_ack in IDLE must not complete anything
    s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
    step();
    s_ack = 1'b0; s_rdata = 32'd0;
    chk("idle_sack_gnt", {30'd0, gnt}, 32'd0);

    // Master drops its request mid-grant: back to IDLE, and last is unchanged
    m0_req = 1'b1;
    wait_gnt("pv_setup", 2'b01);
    push(1'b0, 32'h0000_0055, 1'b0);
    slave_ack(32'h0000_0055, 1'b0);
    m0_req = 1'b0;
    m1_req = 1'b1;
    wait_gnt("pv_gnt1", 2'b10);
    m1_req = 1'b0;
    step();
    chk("pv_idle", {30'd0, gnt}, 32'd0);
    m0_req = 1'b1; m1_req = 1'b1;
    wait_gnt("pv_last_kept", 2'b10);
    push(1'b1, 32'h0000_0066, 1'b0);
    slave_ack(32'h0000_0066, 1'b1);
    m1_req = 1'b0;
    wait_gnt("pv_then_m0", 2'b01);
    push(1'b0, 32'h0000_0077, 1'b0);
    slave_ack(32'h0000_0077, 1'b0);
    m0_req = 1'b0;
    step();

    // Asynchronous reset during GNT1: outputs clear immediately, and m1 gets no ack
    m1_addr = 32'h3000_0000; m1_req = 1'b1;
    wait_gnt("ar_gnt1", 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", {30'd0, gnt}, 32'd0);
    chk("ar_sreq", {31'd0, s_req}, 32'd0);
    chk("ar_saddr", s_addr, 32'd0);
    chk("ar_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    m0_req = 1'b1;
    wait_gnt("ar_post_m0", 2'b01);
    push(1'b0, 32'h0000_0088, 1'b0);
    slave_ack(32'h0000_0088, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0;
    step();

`ifdef DBUS_ARB_TIMEOUT_EN
    // Watchdog: the error completion arrives on the 8th GNT0 cycle
    m0_req = 1'b1;
    push(1'b0, 32'd0, 1'b1);
    wait_gnt("tmo_gnt", 2'b01);
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_ack_timing", {31'd0, m0_ack}, (k == 8) ? 32'd1 : 32'd0);
      chk("tmo_sreq", {31'd0, s_req}, (k == 8) ? 32'd0 : 32'd1);
      if (k < 8) step();
    end
    step();
    m0_req = 1'b0;
    chk("tmo_idle", {30'd0, gnt}, 32'd0);
`else
    // Without the watchdog, the grant waits indefinitely
    m0_req = 1'b1;
    wait_gnt("nt_gnt", 2'b01);
    repeat (1000) step();
    chk("nt_still_gnt", {30'd0, gnt}, 32'd1);
    chk("nt_no_ack", {30'd0, m0_ack, m0_err}, 32'd0);
    m0_req = 1'b0;
    step();
    chk("nt_idle", {30'd0, gnt}, 32'd0);
`endif

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
